// File: rtl/tdm_dmux8_1to4.sv
// 1-to-4 TDM byte demultiplexer: collects W,X,Y,Z bytes framed by sof into registered lanes.
// Optional saturating error counter output err_count when TDM_DMUX_ERRCNT_EN is defined.
module tdm_dmux8_1to4 (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] din,
   input  logic       din_valid,
   input  logic       sof,
   output logic [7:0] W,
   output logic [7:0] X,
   output logic [7:0] Y,
   output logic [7:0] Z,
   output logic       frame_valid,
   output logic       frame_err,
   output logic [1:0] slot
`ifdef TDM_DMUX_ERRCNT_EN
   ,
   output logic [7:0] err_count
`endif
);

   typedef enum logic {StHunt, StCollect} state_e;

   state_e     r_state, w_state_d;
   logic [1:0] r_slot, w_slot_d;
   logic [7:0] r_shadow0, r_shadow1, r_shadow2;
   logic [7:0] w_shadow0_d, w_shadow1_d, w_shadow2_d;
   logic [7:0] r_w, r_x, r_y, r_z;
   logic [7:0] w_w_d, w_x_d, w_y_d, w_z_d;
   logic       r_frame_valid, w_frame_valid_d;
   logic       r_frame_err, w_frame_err_d;
   logic       w_discard;

   always_comb begin
      w_state_d       = r_state;
      w_slot_d        = r_slot;
      w_shadow0_d     = r_shadow0;
      w_shadow1_d     = r_shadow1;
      w_shadow2_d     = r_shadow2;
      w_w_d           = r_w;
      w_x_d           = r_x;
      w_y_d           = r_y;
      w_z_d           = r_z;
      w_frame_valid_d = 1'b0;
      w_frame_err_d   = 1'b0;
      w_discard       = 1'b0;
      if (din_valid) begin
         if (sof) begin
            // An sof mid-frame aborts the partial frame and restarts on this byte.
            w_frame_err_d = (r_state == StCollect);
            w_shadow0_d   = din;
            w_slot_d      = 2'd1;
            w_state_d     = StCollect;
         end else if (r_state == StHunt) begin
            w_discard = 1'b1;
         end else begin
            unique case (r_slot)
               2'd1: begin
                  w_shadow1_d = din;
                  w_slot_d    = 2'd2;
               end
               2'd2: begin
                  w_shadow2_d = din;
                  w_slot_d    = 2'd3;
               end
               default: begin
                  w_w_d           = r_shadow0;
                  w_x_d           = r_shadow1;
                  w_y_d           = r_shadow2;
                  w_z_d           = din;
                  w_frame_valid_d = 1'b1;
                  w_slot_d        = 2'd0;
                  w_state_d       = StHunt;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= StHunt;
         r_slot        <= 2'd0;
         r_shadow0     <= 8'h00;
         r_shadow1     <= 8'h00;
         r_shadow2     <= 8'h00;
         r_w           <= 8'h00;
         r_x           <= 8'h00;
         r_y           <= 8'h00;
         r_z           <= 8'h00;
         r_frame_valid <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_slot        <= w_slot_d;
         r_shadow0     <= w_shadow0_d;
         r_shadow1     <= w_shadow1_d;
         r_shadow2     <= w_shadow2_d;
         r_w           <= w_w_d;
         r_x           <= w_x_d;
         r_y           <= w_y_d;
         r_z           <= w_z_d;
         r_frame_valid <= w_frame_valid_d;
         r_frame_err   <= w_frame_err_d;
      end
   end

   assign W           = r_w;
   assign X           = r_x;
   assign Y           = r_y;
   assign Z           = r_z;
   assign frame_valid = r_frame_valid;
   assign frame_err   = r_frame_err;
   assign slot        = r_slot;

`ifdef TDM_DMUX_ERRCNT_EN
   logic [7:0] r_err_count;

   // Abort and HUNT discard are mutually exclusive, so one increment per cycle suffices.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_count <= 8'h00;
      end else if ((w_frame_err_d || w_discard) && (r_err_count != 8'hFF)) begin
         r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_count = r_err_count;
`else
   logic w_unused;
   assign w_unused = w_discard;
`endif

endmodule

// File: tb/tb_tdm_dmux8_1to4.sv
// Directed self-checking bench for tdm_dmux8_1to4; err_count checks run when
// TDM_DMUX_ERRCNT_EN is defined.
module tb_tdm_dmux8_1to4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] din;
   logic       din_valid;
   logic       sof;
   logic [7:0] W, X, Y, Z;
   logic       frame_valid;
   logic       frame_err;
   logic [1:0] slot;
`ifdef TDM_DMUX_ERRCNT_EN
   logic [7:0] err_count;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   tdm_dmux8_1to4 u_dut (
      .clk         (clk),
      .rst         (rst),
      .din         (din),
      .din_valid   (din_valid),
      .sof         (sof),
      .W           (W),
      .X           (X),
      .Y           (Y),
      .Z           (Z),
      .frame_valid (frame_valid),
      .frame_err   (frame_err),
      .slot        (slot)
`ifdef TDM_DMUX_ERRCNT_EN
      ,
      .err_count   (err_count)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge and sample 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
      check("fv_fe_exclusive", {31'd0, frame_valid & frame_err}, 32'd0);
   endtask

   task automatic send(input logic [7:0] b, input logic s);
      din       = b;
      din_valid = 1'b1;
      sof       = s;
      step();
      din_valid = 1'b0;
      sof       = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic check_lanes(input string tag, input logic [31:0] exp);
      check(tag, {W, X, Y, Z}, exp);
   endtask

   initial begin
      rst       = 1'b0;
      din       = 8'h00;
      din_valid = 1'b0;
      sof       = 1'b0;
      do_reset();
      check_lanes("reset_lanes", 32'h0000_0000);
      check("reset_slot", {30'd0, slot}, 32'd0);
      check("reset_fv", {31'd0, frame_valid}, 32'd0);
      check("reset_fe", {31'd0, frame_err}, 32'd0);

      // Consecutive frame
      send(8'h11, 1'b1);
      check("c_slot1", {30'd0, slot}, 32'd1);
      send(8'h22, 1'b0);
      check("c_slot2", {30'd0, slot}, 32'd2);
      send(8'h33, 1'b0);
      check("c_slot3", {30'd0, slot}, 32'd3);
      check("c_no_early_fv", {31'd0, frame_valid}, 32'd0);
      send(8'h44, 1'b0);
      check_lanes("c_lanes", 32'h1122_3344);
      check("c_fv", {31'd0, frame_valid}, 32'd1);
      check("c_slot0", {30'd0, slot}, 32'd0);
      idle(1);
      check("c_fv_pulse", {31'd0, frame_valid}, 32'd0);
      check_lanes("c_hold", 32'h1122_3344);

      // Gapped frame after reset
      do_reset();
      send(8'h11, 1'b1);
      idle(3);
      check("g_slot1", {30'd0, slot}, 32'd1);
      send(8'h22, 1'b0);
      idle(3);
      check("g_slot2", {30'd0, slot}, 32'd2);
      send(8'h33, 1'b0);
      idle(3);
      check("g_slot3", {30'd0, slot}, 32'd3);
      check_lanes("g_not_yet", 32'h0000_0000);
      send(8'h44, 1'b0);
      check_lanes("g_lanes", 32'h1122_3344);
      check("g_fv", {31'd0, frame_valid}, 32'd1);
      check("g_slot0", {30'd0, slot}, 32'd0);
      idle(2);

      // Abort by early sof
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b0);
      send(8'hCC, 1'b0);
      send(8'hDD, 1'b0);
      check_lanes("a_first", 32'hAABB_CCDD);
      send(8'h01, 1'b1);
      send(8'h02, 1'b0);
      send(8'h05, 1'b1);
      check("a_fe", {31'd0, frame_err}, 32'd1);
      check("a_fv_none", {31'd0, frame_valid}, 32'd0);
      check("a_slot", {30'd0, slot}, 32'd1);
      check_lanes("a_unchanged", 32'hAABB_CCDD);
      send(8'h06, 1'b0);
      check("a_fe_pulse", {31'd0, frame_err}, 32'd0);
      send(8'h07, 1'b0);
      send(8'h08, 1'b0);
      check_lanes("a_lanes", 32'h0506_0708);
      check("a_fv", {31'd0, frame_valid}, 32'd1);

      // Back-to-back frame straight after the Z byte
      send(8'h10, 1'b1);
      check("b_fe", {31'd0, frame_err}, 32'd0);
      check("b_slot", {30'd0, slot}, 32'd1);
      send(8'h20, 1'b0);
      send(8'h30, 1'b0);
      send(8'h40, 1'b0);
      check_lanes("b_lanes", 32'h1020_3040);
      check("b_fv", {31'd0, frame_valid}, 32'd1);

      // Sof-less bytes discarded in HUNT
      do_reset();
      send(8'h77, 1'b0);
      send(8'h78, 1'b0);
      send(8'h79, 1'b0);
      check("d_slot", {30'd0, slot}, 32'd0);
      check("d_fe", {31'd0, frame_err}, 32'd0);
      send(8'hA1, 1'b1);
      send(8'hA2, 1'b0);
      send(8'hA3, 1'b0);
      send(8'hA4, 1'b0);
      check_lanes("d_lanes", 32'hA1A2_A3A4);
      check("d_fv", {31'd0, frame_valid}, 32'd1);
`ifdef TDM_DMUX_ERRCNT_EN
      check("d_errcnt", {24'd0, err_count}, 32'd3);
`endif

      // Reset mid-frame, with rst overriding a concurrent sof byte
      send(8'h55, 1'b1);
      send(8'h66, 1'b0);
      rst       = 1'b1;
      din       = 8'hEE;
      din_valid = 1'b1;
      sof       = 1'b1;
      step();
      rst       = 1'b0;
      din_valid = 1'b0;
      sof       = 1'b0;
      check_lanes("r_lanes", 32'h0000_0000);
      check("r_slot", {30'd0, slot}, 32'd0);
      check("r_fv", {31'd0, frame_valid}, 32'd0);
      check("r_fe", {31'd0, frame_err}, 32'd0);
      send(8'h99, 1'b0);
      check("r_discard_slot", {30'd0, slot}, 32'd0);
      send(8'hC1, 1'b1);
      send(8'hC2, 1'b0);
      send(8'hC3, 1'b0);
      send(8'hC4, 1'b0);
      check_lanes("r_next_frame", 32'hC1C2_C3C4);
      check("r_next_fv", {31'd0, frame_valid}, 32'd1);

`ifdef TDM_DMUX_ERRCNT_EN
      do_reset();
      check("s_errcnt_reset", {24'd0, err_count}, 32'd0);
      for (int i = 0; i < 300; i++) send(i[7:0], 1'b0);
      check("s_errcnt_sat", {24'd0, err_count}, 32'd255);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
